encoder_capture_ctrl: RTL

- Sequences position measurement on the filtered, edge-detected grating signals: the rotary grating (A/B/Z) and the linear grating (A/B).
- Arms on a start command and optionally homes on the rotary Z index.
- Keeps signed up/down counts for both gratings plus a revolution count, and captures a coherent snapshot every SAMPLE_DIV rotary steps.
- Snapshots go into a one-deep result slot with a valid/ready handshake. Sits between the signal filter/edge detect front end and the host readout logic.

---
 rtl/encoder_capture_ctrl_pkg.sv | 20 ++
 rtl/encoder_capture_ctrl_if.sv | 54 +++++
 rtl/encoder_capture_ctrl_updown_counter.sv | 38 +++
 rtl/encoder_capture_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/encoder_capture_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// encoder_pkg
// Shared definitions for the encoder capture controller:
//   - state_e   : sequencer state encoding (also the value driven on oState)
//   - CNT_W_DEF : default width of the rotary/linear position counters
//   - REV_W_DEF : default width of the revolution counter
// ----------------------------------------------------------------------------
package encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_Z = 2'd1,
        ST_RUN    = 2'd2,
        ST_FLUSH  = 2'd3
    } state_e;

    localparam int CNT_W_DEF = 16;
    localparam int REV_W_DEF = 8;

endpackage

// File: rtl/encoder_capture_ctrl_if.sv
// ----------------------------------------------------------------------------
// encoder_capture_ctrl_if
// Groups the command, grating-event and result-slot signals of the capture
// controller.
//   Commands   : iStart, iStop, iHome_en
//   Rotary     : iRESR_step, iRESR_dir, iRESR_index
//   Linear     : iRGS_step, iRGS_dir
//   Result     : oValid/iReady handshake, oPos_rot, oPos_lin, oRev, oLast
//   Status     : oOverrun, oState, oBusy
// Handshake: a snapshot is transferred on a rising clock edge where
// oValid=1 and iReady=1. While oValid=1 the payload (oPos_rot, oPos_lin,
// oRev, oLast) is held stable; oValid never drops without iReady.
// Modports: master = front end / host side, slave = capture controller.
// ----------------------------------------------------------------------------
interface encoder_capture_ctrl_if
    import encoder_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int REV_W = REV_W_DEF
);
    logic             iStart;
    logic             iStop;
    logic             iHome_en;
    logic             iRESR_step;
    logic             iRESR_dir;
    logic             iRESR_index;
    logic             iRGS_step;
    logic             iRGS_dir;
    logic             iReady;
    logic             oValid;
    logic [CNT_W-1:0] oPos_rot;
    logic [CNT_W-1:0] oPos_lin;
    logic [REV_W-1:0] oRev;
    logic             oLast;
    logic             oOverrun;
    logic [1:0]       oState;
    logic             oBusy;

    modport master (
        output iStart, iStop, iHome_en,
        output iRESR_step, iRESR_dir, iRESR_index,
        output iRGS_step, iRGS_dir, iReady,
        input  oValid, oPos_rot, oPos_lin, oRev, oLast,
        input  oOverrun, oState, oBusy
    );

    modport slave (
        input  iStart, iStop, iHome_en,
        input  iRESR_step, iRESR_dir, iRESR_index,
        input  iRGS_step, iRGS_dir, iReady,
        output oValid, oPos_rot, oPos_lin, oRev, oLast,
        output oOverrun, oState, oBusy
    );
endinterface

// File: rtl/encoder_capture_ctrl_updown_counter.sv
// ----------------------------------------------------------------------------
// updown_counter
// Signed wrap-around up/down counter.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   clr        : synchronous clear, has priority over en
//   en         : count one step this cycle
//   up         : 1 = +1, 0 = -1
//   count      : current count (two's complement, wraps modulo 2^W)
// ----------------------------------------------------------------------------
module updown_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic         up,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = up ? count_q + W'(1) : count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/encoder_capture_ctrl.sv
// ----------------------------------------------------------------------------
// encoder_capture_ctrl
// Sequences position measurement on edge-detected rotary (A/B/Z) and linear
// (A/B) grating events and publishes coherent snapshots through a one-deep
// result slot.
//   CLOCK_50M : system clock (rising edge)
//   RST_n     : asynchronous active-low reset
//   bus       : encoder_capture_ctrl_if.slave (commands, grating events,
//               result slot handshake and status)
// Parameters: CNT_W/REV_W counter widths, SAMPLE_DIV rotary steps per
// periodic capture (1 .. 2^CNT_W-1).
// ----------------------------------------------------------------------------
module encoder_capture_ctrl
    import encoder_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int REV_W      = REV_W_DEF,
    parameter int SAMPLE_DIV = 4
) (
    input logic                  CLOCK_50M,
    input logic                  RST_n,
    encoder_capture_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SAMPLE_DIV - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             ovr_q, ovr_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] pos_rot_q, pos_rot_d;
    logic [CNT_W-1:0] pos_lin_q, pos_lin_d;
    logic [REV_W-1:0] rev_q, rev_d;

    logic             cnt_clr, start_cmd, stop_cap;
    logic             run, rot_en, lin_en, rev_en;
    logic             per_cap, slot_free, flush_load, load;
    logic [CNT_W-1:0] rot_cnt, lin_cnt;
    logic [REV_W-1:0] rev_cnt;
    logic [CNT_W-1:0] rot_post, lin_post;
    logic [REV_W-1:0] rev_post;

    assign run    = (state_q == ST_RUN);
    assign rot_en = run && bus.iRESR_step;
    assign lin_en = run && bus.iRGS_step;
    assign rev_en = run && bus.iRESR_index;

    updown_counter #(.W(CNT_W)) u_rot (
        .clk(CLOCK_50M), .rst_n(RST_n), .clr(cnt_clr),
        .en(rot_en), .up(bus.iRESR_dir), .count(rot_cnt));
    updown_counter #(.W(CNT_W)) u_lin (
        .clk(CLOCK_50M), .rst_n(RST_n), .clr(cnt_clr),
        .en(lin_en), .up(bus.iRGS_dir), .count(lin_cnt));
    updown_counter #(.W(REV_W)) u_rev (
        .clk(CLOCK_50M), .rst_n(RST_n), .clr(cnt_clr),
        .en(rev_en), .up(bus.iRESR_dir), .count(rev_cnt));

    // Snapshots carry the counts as they will be after this edge, so a step
    // arriving in the capture cycle is included.
    assign rot_post = !rot_en ? rot_cnt :
                      bus.iRESR_dir ? rot_cnt + CNT_W'(1) : rot_cnt - CNT_W'(1);
    assign lin_post = !lin_en ? lin_cnt :
                      bus.iRGS_dir ? lin_cnt + CNT_W'(1) : lin_cnt - CNT_W'(1);
    assign rev_post = !rev_en ? rev_cnt :
                      bus.iRESR_dir ? rev_cnt + REV_W'(1) : rev_cnt - REV_W'(1);

    // Sequencer
    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b0;
        start_cmd = 1'b0;
        stop_cap  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.iStart) begin
                    start_cmd = 1'b1;
                    if (bus.iHome_en) begin
                        state_d = ST_WAIT_Z;
                    end else begin
                        state_d = ST_RUN;
                        cnt_clr = 1'b1;
                    end
                end
            end
            ST_WAIT_Z: begin
                if (bus.iRESR_index) begin
                    state_d = ST_RUN;
                    cnt_clr = 1'b1;
                end else if (bus.iStop) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.iStop) begin
                    state_d  = ST_FLUSH;
                    stop_cap = 1'b1;
                end
            end
            ST_FLUSH: begin
                // The slot holds the final snapshot only once nothing is
                // pending and oLast is set; leave when it is taken.
                if (!pend_q && valid_q && last_q && bus.iReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Divider and result slot
    assign per_cap    = rot_en && (div_q == DIV_LAST);
    assign slot_free  = !valid_q || bus.iReady;
    assign flush_load = (state_q == ST_FLUSH) && pend_q && slot_free;
    assign load       = (stop_cap || per_cap || flush_load) && slot_free;

    always_comb begin
        div_d     = div_q;
        valid_d   = valid_q;
        last_d    = last_q;
        ovr_d     = ovr_q;
        pend_d    = pend_q;
        pos_rot_d = pos_rot_q;
        pos_lin_d = pos_lin_q;
        rev_d     = rev_q;

        if (cnt_clr) begin
            div_d = '0;
        end else if (rot_en) begin
            div_d = per_cap ? '0 : div_q + CNT_W'(1);
        end

        if (valid_q && bus.iReady) valid_d = 1'b0;
        if (start_cmd) ovr_d = 1'b0;

        if (load) begin
            valid_d   = 1'b1;
            last_d    = stop_cap || flush_load;
            pos_rot_d = rot_post;
            pos_lin_d = lin_post;
            rev_d     = rev_post;
        end

        // A stop capture is never dropped; it waits in FLUSH for the slot.
        if (stop_cap && !slot_free) pend_d = 1'b1;
        if (flush_load)             pend_d = 1'b0;
        // A periodic capture that coincides with stop is superseded, not lost.
        if (per_cap && !stop_cap && !slot_free) ovr_d = 1'b1;
    end

    always_ff @(posedge CLOCK_50M or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            ovr_q     <= 1'b0;
            pend_q    <= 1'b0;
            pos_rot_q <= '0;
            pos_lin_q <= '0;
            rev_q     <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            ovr_q     <= ovr_d;
            pend_q    <= pend_d;
            pos_rot_q <= pos_rot_d;
            pos_lin_q <= pos_lin_d;
            rev_q     <= rev_d;
        end
    end

    assign bus.oValid   = valid_q;
    assign bus.oPos_rot = pos_rot_q;
    assign bus.oPos_lin = pos_lin_q;
    assign bus.oRev     = rev_q;
    assign bus.oLast    = last_q;
    assign bus.oOverrun = ovr_q;
    assign bus.oState   = state_q;
    assign bus.oBusy    = (state_q != ST_IDLE);
endmodule
